// File: rtl/otter_pkg.sv
// otter_pkg: shared OTTER pipeline types and constants.
// Holds the RV32I major opcodes, the pipeline-control FSM states
// and the EX operand forwarding-select encodings.
package otter_pkg;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011,
      OP_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [1:0] {RUN, DRAIN, TRAP} ctrl_state_t;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/otter_fwd_unit.sv
// otter_fwd_unit: combinational EX-operand forwarding select for one source.
// Ports:
//   rs_addr, rs_used            - EX source register and whether it is read
//   mem_rd_addr, mem_reg_write,
//   mem_mem_read                - MEM stage destination info
//   wb_rd_addr, wb_reg_write    - WB stage destination info
//   sel                         - FWD_RF / FWD_MEM / FWD_WB
module otter_fwd_unit
   import otter_pkg::*;
(
   input  logic [4:0] rs_addr,
   input  logic       rs_used,
   input  logic [4:0] mem_rd_addr,
   input  logic       mem_reg_write,
   input  logic       mem_mem_read,
   input  logic [4:0] wb_rd_addr,
   input  logic       wb_reg_write,
   output logic [1:0] sel
);

   logic mem_hit;
   logic wb_hit;

   // A load in MEM has no data yet; its consumer was already stalled one
   // cycle, so it picks the value up from WB instead.
   assign mem_hit = mem_reg_write & ~mem_mem_read & (mem_rd_addr != 5'd0) &
                    (mem_rd_addr == rs_addr) & rs_used;
   assign wb_hit  = wb_reg_write & (wb_rd_addr != 5'd0) &
                    (wb_rd_addr == rs_addr) & rs_used;
   assign sel     = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;

endmodule

// File: rtl/otter_pipe_ctrl.sv
// otter_pipe_ctrl: hazard, redirect, forwarding and interrupt-entry control
// for the 5-stage OTTER pipeline.
// Ports:
//   CLK, RESET_N                  - clock, asynchronous active-low reset
//   id_* / if_pc                  - ID instruction sources, PC and fetch PC
//   ex_* / mem_* / wb_*           - downstream stage register usage
//   ex_redirect                   - control transfer resolved in EX
//   INTR, mie                     - external interrupt level and enable
//   pc_write, if_id_en            - PC / IF-ID load enables
//   if_id_flush, id_ex_flush      - bubble insertion
//   fwd_a_sel, fwd_b_sel          - EX operand forwarding selects
//   trap_pc_sel, int_taken        - trap redirect and CSR trap update
//   trap_mepc                     - latched return PC
//   stall_cnt, flush_cnt          - performance counters
module otter_pipe_ctrl
   import otter_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [31:0] id_pc,
   input  logic [31:0] if_pc,
   input  logic [4:0]  ex_rs1_addr,
   input  logic [4:0]  ex_rs2_addr,
   input  logic        ex_rs1_used,
   input  logic        ex_rs2_used,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic [4:0]  mem_rd_addr,
   input  logic        mem_reg_write,
   input  logic        mem_mem_read,
   input  logic [4:0]  wb_rd_addr,
   input  logic        wb_reg_write,
   input  logic        INTR,
   input  logic        mie,
   output logic        pc_write,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        trap_pc_sel,
   output logic        int_taken,
   output logic [31:0] trap_mepc,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   ctrl_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic pending_q;
   logic lu, enter, stall_c;
   logic pc_write_c, if_id_en_c, if_id_flush_c, id_ex_flush_c;
   logic trap_pc_sel_c, int_taken_c;
   logic [1:0] fwd_a_c, fwd_b_c;

   otter_fwd_unit u_fwd_a (
      .rs_addr       (ex_rs1_addr),
      .rs_used       (ex_rs1_used),
      .mem_rd_addr   (mem_rd_addr),
      .mem_reg_write (mem_reg_write),
      .mem_mem_read  (mem_mem_read),
      .wb_rd_addr    (wb_rd_addr),
      .wb_reg_write  (wb_reg_write),
      .sel           (fwd_a_c)
   );

   otter_fwd_unit u_fwd_b (
      .rs_addr       (ex_rs2_addr),
      .rs_used       (ex_rs2_used),
      .mem_rd_addr   (mem_rd_addr),
      .mem_reg_write (mem_reg_write),
      .mem_mem_read  (mem_mem_read),
      .wb_rd_addr    (wb_rd_addr),
      .wb_reg_write  (wb_reg_write),
      .sel           (fwd_b_c)
   );

   assign lu = ex_mem_read & ex_reg_write & (ex_rd_addr != 5'd0) & id_valid &
               ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      enter         = 1'b0;
      stall_c       = 1'b0;
      pc_write_c    = 1'b1;
      if_id_en_c    = 1'b1;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      trap_pc_sel_c = 1'b0;
      int_taken_c   = 1'b0;
      case (state_q)
         RUN: begin
            // Redirect beats load-use: the stalled ID instruction is wrong-path.
            if (ex_redirect) begin
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
            end else if (lu) begin
               pc_write_c    = 1'b0;
               if_id_en_c    = 1'b0;
               id_ex_flush_c = 1'b1;
               stall_c       = 1'b1;
            end else if (pending_q) begin
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
               enter         = 1'b1;
               cnt_d         = CW'(DRAIN_CYCLES - 1);
               state_d       = DRAIN;
            end
         end
         DRAIN: begin
            pc_write_c    = 1'b0;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            if (cnt_q == '0) state_d = TRAP;
            else cnt_d = cnt_q - 1'b1;
         end
         TRAP: begin
            trap_pc_sel_c = 1'b1;
            int_taken_c   = 1'b1;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            state_d       = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Hold the combinational outputs at their idle values while in reset.
   assign pc_write    = ~RESET_N | pc_write_c;
   assign if_id_en    = ~RESET_N | if_id_en_c;
   assign if_id_flush = RESET_N & if_id_flush_c;
   assign id_ex_flush = RESET_N & id_ex_flush_c;
   assign trap_pc_sel = RESET_N & trap_pc_sel_c;
   assign int_taken   = RESET_N & int_taken_c;
   assign fwd_a_sel   = RESET_N ? fwd_a_c : FWD_RF;
   assign fwd_b_sel   = RESET_N ? fwd_b_c : FWD_RF;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         trap_mepc <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         // Clear wins so a still-asserted INTR cannot re-arm during the trap.
         pending_q <= int_taken_c ? 1'b0 : (pending_q | (INTR & mie));
         if (enter) trap_mepc <= id_valid ? id_pc : if_pc;
         stall_cnt <= stall_cnt + 32'(stall_c);
         flush_cnt <= flush_cnt + 32'(if_id_flush_c);
      end
   end

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// tb_otter_pipe_ctrl: directed scoreboard bench for otter_pipe_ctrl.
module tb_otter_pipe_ctrl;

   logic        CLK, RESET_N;
   logic        id_valid, id_rs1_used, id_rs2_used;
   logic [4:0]  id_rs1_addr, id_rs2_addr;
   logic [31:0] id_pc, if_pc;
   logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
   logic        ex_rs1_used, ex_rs2_used, ex_reg_write, ex_mem_read, ex_redirect;
   logic [4:0]  mem_rd_addr, wb_rd_addr;
   logic        mem_reg_write, mem_mem_read, wb_reg_write;
   logic        INTR, mie;
   logic        pc_write, if_id_en, if_id_flush, id_ex_flush;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        trap_pc_sel, int_taken;
   logic [31:0] trap_mepc, stall_cnt, flush_cnt;

   otter_pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_pc(id_pc), .if_pc(if_pc),
      .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
      .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
      .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_redirect(ex_redirect),
      .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
      .INTR(INTR), .mie(mie),
      .pc_write(pc_write), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .trap_pc_sel(trap_pc_sel), .int_taken(int_taken),
      .trap_mepc(trap_mepc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;

   localparam int S_PCW = 0, S_IFEN = 1, S_IFFL = 2, S_IDFL = 3, S_FA = 4, S_FB = 5,
                  S_TPS = 6, S_INT = 7, S_MEPC = 8, S_STALL = 9, S_FLUSH = 10;

   function automatic logic [31:0] obs(int s);
      case (s)
         S_PCW:   return {31'd0, pc_write};
         S_IFEN:  return {31'd0, if_id_en};
         S_IFFL:  return {31'd0, if_id_flush};
         S_IDFL:  return {31'd0, id_ex_flush};
         S_FA:    return {30'd0, fwd_a_sel};
         S_FB:    return {30'd0, fwd_b_sel};
         S_TPS:   return {31'd0, trap_pc_sel};
         S_INT:   return {31'd0, int_taken};
         S_MEPC:  return trap_mepc;
         S_STALL: return stall_cnt;
         S_FLUSH: return flush_cnt;
         default: return 'x;
      endcase
   endfunction

   task automatic push(string tag, int s, logic [31:0] v);
      q.push_back('{tag, s, v});
   endtask

   task automatic ctl(string tag, logic pcw, logic ifen, logic iffl, logic idfl);
      push({tag, ".pc_write"}, S_PCW, {31'd0, pcw});
      push({tag, ".if_id_en"}, S_IFEN, {31'd0, ifen});
      push({tag, ".if_id_flush"}, S_IFFL, {31'd0, iffl});
      push({tag, ".id_ex_flush"}, S_IDFL, {31'd0, idfl});
   endtask

   task automatic trp(string tag, logic tps, logic it);
      push({tag, ".trap_pc_sel"}, S_TPS, {31'd0, tps});
      push({tag, ".int_taken"}, S_INT, {31'd0, it});
   endtask

   task automatic cnts(string tag, int st, int fl);
      push({tag, ".stall_cnt"}, S_STALL, st);
      push({tag, ".flush_cnt"}, S_FLUSH, fl);
   endtask

   task automatic check();
      exp_t e;
      logic [31:0] o;
      while (q.size() > 0) begin
         e = q.pop_front();
         o = obs(e.sig);
         tests++;
         assert (o === e.val) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic clr();
      id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_pc = 0; if_pc = 0;
      ex_rs1_addr = 0; ex_rs2_addr = 0; ex_rs1_used = 0; ex_rs2_used = 0;
      ex_rd_addr = 0; ex_reg_write = 0; ex_mem_read = 0; ex_redirect = 0;
      mem_rd_addr = 0; mem_reg_write = 0; mem_mem_read = 0;
      wb_rd_addr = 0; wb_reg_write = 0;
      INTR = 0; mie = 0;
   endtask

   task automatic load_use(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2, logic [4:0] rd);
      ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = rd; id_valid = 1;
      id_rs1_addr = rs1; id_rs1_used = u1; id_rs2_addr = rs2; id_rs2_used = u2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      RESET_N = 0;
      // Inputs that would flush/forward must be masked during reset.
      ex_redirect = 1; ex_rs1_addr = 3; ex_rs1_used = 1; mem_rd_addr = 3; mem_reg_write = 1;
      #2;
      ctl("reset", 1, 1, 0, 0); trp("reset", 0, 0);
      push("reset.fwd_a", S_FA, 0); push("reset.fwd_b", S_FB, 0);
      push("reset.mepc", S_MEPC, 0); cnts("reset", 0, 0);
      check();

      @(negedge CLK); RESET_N = 1; clr(); #2;
      ctl("idle", 1, 1, 0, 0); trp("idle", 0, 0); check();

      // Load x5 in EX, consumer of x5 in ID.
      @(negedge CLK); load_use(5, 1, 0, 0, 5); #2;
      ctl("lu", 0, 0, 0, 1); cnts("lu", 0, 0); check();
      // Bubble in EX, load in MEM.
      @(negedge CLK); clr(); id_valid = 1; id_rs1_addr = 5; id_rs1_used = 1;
      mem_rd_addr = 5; mem_reg_write = 1; mem_mem_read = 1; #2;
      ctl("lu_after", 1, 1, 0, 0); push("lu_after.fwd_a", S_FA, 0); cnts("lu_after", 1, 0); check();
      // Consumer in EX, load in WB.
      @(negedge CLK); clr(); ex_rs1_addr = 5; ex_rs1_used = 1; wb_rd_addr = 5; wb_reg_write = 1; #2;
      push("lu_wb.fwd_a", S_FA, 2); push("lu_wb.fwd_b", S_FB, 0); cnts("lu_wb", 1, 0); check();
      // A load still in MEM is not a MEM forward source.
      @(negedge CLK); mem_rd_addr = 5; mem_reg_write = 1; mem_mem_read = 1; #2;
      push("memload.fwd_a", S_FA, 2); check();
      // Load into x0 never stalls.
      @(negedge CLK); clr(); load_use(0, 1, 0, 1, 0); #2;
      ctl("lu_x0", 1, 1, 0, 0); check();
      // Matching rs1 that is not read does not stall.
      @(negedge CLK); clr(); load_use(9, 0, 4, 1, 9); #2;
      ctl("lu_unused", 1, 1, 0, 0); check();
      // rs2 match stalls.
      @(negedge CLK); clr(); load_use(1, 1, 12, 1, 12); #2;
      ctl("lu_rs2", 0, 0, 0, 1); cnts("lu_rs2", 1, 0); check();
      // MEM beats WB.
      @(negedge CLK); clr(); ex_rs2_addr = 7; ex_rs2_used = 1;
      mem_rd_addr = 7; mem_reg_write = 1; wb_rd_addr = 7; wb_reg_write = 1; #2;
      push("dual.fwd_b", S_FB, 1); push("dual.fwd_a", S_FA, 0); cnts("dual", 2, 0); check();
      @(negedge CLK); ex_rs2_addr = 0; mem_rd_addr = 0; wb_rd_addr = 0; #2;
      push("dual_x0.fwd_b", S_FB, 0); check();
      @(negedge CLK); ex_rs2_addr = 7; mem_rd_addr = 7; wb_rd_addr = 7; ex_rs2_used = 0; #2;
      push("dual_unused.fwd_b", S_FB, 0); check();
      @(negedge CLK); ex_rs1_addr = 7; ex_rs1_used = 1; mem_reg_write = 0; #2;
      push("wb_only.fwd_a", S_FA, 2); check();

      // Redirect together with load-use.
      @(negedge CLK); clr(); load_use(6, 1, 0, 0, 6); ex_redirect = 1; #2;
      ctl("rd_lu", 1, 1, 1, 1); cnts("rd_lu", 2, 0); check();
      @(negedge CLK); clr(); #2;
      ctl("rd_lu_after", 1, 1, 0, 0); cnts("rd_lu_after", 2, 1); check();

      // Interrupt pulse, ID holds PC 0x100.
      @(negedge CLK); INTR = 1; mie = 1; id_valid = 1; id_pc = 32'h100; if_pc = 32'h200; #2;
      ctl("int_a", 1, 1, 0, 0); trp("int_a", 0, 0); check();
      @(negedge CLK); INTR = 0; #2;
      ctl("int_enter", 1, 1, 1, 1); trp("int_enter", 0, 0); check();
      @(negedge CLK); id_pc = 32'h104; #2;
      ctl("drain1", 0, 1, 1, 1); trp("drain1", 0, 0); push("drain1.mepc", S_MEPC, 32'h100); check();
      @(negedge CLK); ex_redirect = 1; ex_rs1_addr = 8; ex_rs1_used = 1; mem_rd_addr = 8; mem_reg_write = 1; #2;
      ctl("drain2", 0, 1, 1, 1); push("drain2.fwd_a", S_FA, 1); check();
      @(negedge CLK); clr(); #2;
      ctl("drain3", 0, 1, 1, 1); trp("drain3", 0, 0); cnts("drain3", 2, 4); check();
      @(negedge CLK); #2;
      ctl("trap", 1, 1, 1, 1); trp("trap", 1, 1); push("trap.mepc", S_MEPC, 32'h100); check();
      @(negedge CLK); #2;
      ctl("post_trap", 1, 1, 0, 0); trp("post_trap", 0, 0); cnts("post_trap", 2, 6); check();
      @(negedge CLK); #2;
      ctl("post_trap2", 1, 1, 0, 0); trp("post_trap2", 0, 0); check();

      // Interrupt blocked one cycle by a redirect.
      @(negedge CLK); INTR = 1; mie = 1; id_valid = 1; id_pc = 32'h300; #2;
      ctl("blk_a", 1, 1, 0, 0); check();
      @(negedge CLK); INTR = 0; ex_redirect = 1; #2;
      ctl("blk_rd", 1, 1, 1, 1); trp("blk_rd", 0, 0); check();
      @(negedge CLK); ex_redirect = 0; id_pc = 32'h340; #2;
      ctl("blk_enter", 1, 1, 1, 1); check();
      @(negedge CLK); #2;
      ctl("blk_drain1", 0, 1, 1, 1); push("blk_drain1.mepc", S_MEPC, 32'h340); check();
      @(negedge CLK); #2;
      ctl("blk_drain2", 0, 1, 1, 1); check();
      @(negedge CLK); #2;
      ctl("blk_drain3", 0, 1, 1, 1); trp("blk_drain3", 0, 0); check();
      @(negedge CLK); #2;
      trp("blk_trap", 1, 1); push("blk_trap.mepc", S_MEPC, 32'h340); check();
      @(negedge CLK); clr(); #2;
      ctl("blk_post", 1, 1, 0, 0); cnts("blk_post", 2, 12); check();

      // INTR without mie is ignored.
      @(negedge CLK); INTR = 1; #2;
      @(negedge CLK); INTR = 0; #2;
      ctl("no_mie", 1, 1, 0, 0); check();

      // Reset in the second DRAIN cycle; ID empty so the fetch PC is latched.
      @(negedge CLK); INTR = 1; mie = 1; if_pc = 32'h500; #2;
      @(negedge CLK); INTR = 0; #2;
      ctl("rst_enter", 1, 1, 1, 1); check();
      @(negedge CLK); #2;
      ctl("rst_drain1", 0, 1, 1, 1); push("rst_drain1.mepc", S_MEPC, 32'h500); check();
      @(negedge CLK); #2;
      ctl("rst_drain2", 0, 1, 1, 1); check();
      #1 RESET_N = 0; #1;
      ctl("rst_mid", 1, 1, 0, 0); trp("rst_mid", 0, 0);
      push("rst_mid.mepc", S_MEPC, 0); cnts("rst_mid", 0, 0); check();
      @(negedge CLK); RESET_N = 1; clr(); #2;
      for (int i = 0; i < 6; i++) begin
         ctl("rst_post", 1, 1, 0, 0); trp("rst_post", 0, 0); check();
         @(negedge CLK); #2;
      end
      cnts("rst_end", 0, 0); check();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
